dmem_responder: RTL and testbench

Request/response data-memory responder for the multicycle core's MEM stage. It accepts one load or store per handshake from the core-side requester. It inserts a fixed number of wait cycles, performs the access on a word-organised RAM, and returns a one-cycle `ready` pulse carrying read data and an error flag. It replaces the core's zero-latency data memory, so the controller must stall in MEM until `ready`.

---
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the multicycle core's MEM stage: IDLE -> WAIT -> RESP.
// Optional byte-enable stores are compiled in with `define DMEM_BYTE_EN_EN.
module dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [1:0]  be,
`endif
  output logic        ready,
  output logic [15:0] rdata,
  output logic        err
);
  localparam int DATA_W = 16;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 we_p0;
  logic [15:0]          addr_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic [1:0]           be_p0;
  logic                 bad_p0;
  logic [IDX_W-1:0]     idx_p0;
  logic                 access;
  logic                 mem_we;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign bad_p0 = addr_p0[0] || ({1'b0, addr_p0[15:1]} >= 16'(DEPTH));
  assign idx_p0 = addr_p0[IDX_W:1];
  assign access = (state == WAIT) && (cnt == 4'd0);
  // reset on the access edge must suppress the write, so it gates the enable directly
  assign mem_we = access && !reset && !bad_p0 && we_p0;

  // request capture: transaction fields frozen at acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
`ifdef DMEM_BYTE_EN_EN
      be_p0    <= be;
`endif
    end
  end

`ifndef DMEM_BYTE_EN_EN
  assign be_p0 = 2'b11;
`endif

  // access stage: byte-lane RAM write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 2; b++) begin
        if (be_p0[b]) mem[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
      end
    end
  end

  // control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (req) begin
            cnt   <= 4'(WAIT_CYCLES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready <= 1'b1;
            err   <= bad_p0;
            state <= RESP;
            if (bad_p0)      rdata <= '0;
            else if (!we_p0) rdata <= mem[idx_p0];
          end
        end
        RESP: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model results, a negedge monitor pops on ready.
module tb_dmem_responder;
  localparam int DEPTH = 32;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready;
  logic [15:0] rdata;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [15:0] ref_mem [DEPTH];
  logic [15:0] last_rdata;
  logic [16:0] sb [$];
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef DMEM_BYTE_EN_EN
    .be    (be),
`endif
    .ready (ready),
    .rdata (rdata),
    .err   (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: word-addressed memory, error on odd address or index beyond DEPTH.
  task automatic model_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] b);
    int idx;
    logic [1:0] eb;
    idx = int'(a >> 1);
`ifdef DMEM_BYTE_EN_EN
    eb = b;
`else
    eb = 2'b11;
`endif
    if (a[0] || idx >= DEPTH) begin
      last_rdata = 16'h0;
      sb.push_back({16'h0, 1'b1});
    end else if (w) begin
      if (eb[0]) ref_mem[idx][7:0]  = d[7:0];
      if (eb[1]) ref_mem[idx][15:8] = d[15:8];
      sb.push_back({last_rdata, 1'b0});
    end else begin
      last_rdata = ref_mem[idx];
      sb.push_back({last_rdata, 1'b0});
    end
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] b, input bit scramble);
    int edges;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    model_txn(w, a, d, b);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req = 1'b0;
    if (scramble) begin
      we = ~w; addr = 16'h000A; wdata = 16'h5555; be = 2'b11;
    end
    while (!ready && edges < WC + 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", edges, WC + 2);
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset && ready) begin
      check("ready_gap", prev_ready, 1'b0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got ready=1, expected no response");
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e[16:1]);
        check("err", err, e[0]);
      end
    end
    prev_ready = ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int last_cyc;
    int n;
    int cyc;
    int r;
    logic [15:0] ra;
    req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0; be = 2'b11;
    reset = 1'b1;
    last_rdata = 16'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", ready, 1'b0);
    check("reset_rdata", rdata, 16'h0);
    check("reset_err", err, 1'b0);
    reset = 1'b0;

    issue(1'b1, 16'h0004, 16'hBEEF, 2'b11, 1'b0);
    issue(1'b0, 16'h0004, 16'h0000, 2'b11, 1'b0);
    issue(1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0);
    issue(1'b0, 16'h0040, 16'h0000, 2'b11, 1'b0);
    issue(1'b0, 16'h0002, 16'h0000, 2'b11, 1'b0);
    issue(1'b0, 16'h0004, 16'h0000, 2'b11, 1'b0);

    // store aborted by reset on its access edge
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0002; wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (WC) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", ready, 1'b0);
    check("abort_rdata", rdata, 16'h0);
    check("abort_err", err, 1'b0);
    reset = 1'b0;
    last_rdata = 16'h0;
    repeat (WC + 4) @(negedge clk);
    issue(1'b0, 16'h0002, 16'h0000, 2'b11, 1'b0);

    issue(1'b1, 16'h0008, 16'hAAAA, 2'b11, 1'b1);
    issue(1'b0, 16'h0008, 16'h0000, 2'b11, 1'b0);
    issue(1'b0, 16'h000A, 16'h0000, 2'b11, 1'b0);

    // continuous request: load repeats every WC+3 cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0006; wdata = 16'h0;
    repeat (4) model_txn(1'b0, 16'h0006, 16'h0, 2'b11);
    n = 0; cyc = 0; last_cyc = 0;
    while (n < 4 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ready) begin
        if (n == 0) check("hold_first", cyc, WC + 2);
        else        check("hold_period", cyc - last_cyc, WC + 3);
        last_cyc = cyc;
        n++;
        if (n == 4) req = 1'b0;
      end
    end
    req = 1'b0;
    check("hold_count", n, 4);

`ifdef DMEM_BYTE_EN_EN
    issue(1'b1, 16'h0010, 16'h1200, 2'b11, 1'b0);
    issue(1'b1, 16'h0010, 16'hFFFF, 2'b01, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0);
    check("be_model", ref_mem[8], 16'h12FF);
    issue(1'b1, 16'h0010, 16'hABCD, 2'b00, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0);
`endif

    repeat (40) begin
      r = $urandom_range(0, 9);
      ra = 16'($urandom_range(0, DEPTH - 1)) << 1;
      if (r == 7) ra = ra | 16'h0001;
      if (r >= 8) ra = 16'($urandom_range(DEPTH, 32767)) << 1;
      issue(1'($urandom_range(0, 1)), ra, 16'($urandom), 2'($urandom), 1'b0);
    end

    repeat (WC + 5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
